// File: rtl/wb_rr_interconnect_if.sv
// Wishbone shared-bus bundle: per-master request/response vectors plus the shared slave fan-out.
// The interconnect connects through the slave modport; the masters and slaves connect through master.
interface wb_rr_interconnect_if #(
    parameter int N_MASTERS = 5,
    parameter int N_SLAVES  = 6
);
    logic [32*N_MASTERS-1:0] m_adr_i;
    logic [32*N_MASTERS-1:0] m_dat_i;
    logic [31:0]             m_dat_o;
    logic [3*N_MASTERS-1:0]  m_cti_i;
    logic [4*N_MASTERS-1:0]  m_sel_i;
    logic [N_MASTERS-1:0]    m_we_i;
    logic [N_MASTERS-1:0]    m_cyc_i;
    logic [N_MASTERS-1:0]    m_stb_i;
    logic [N_MASTERS-1:0]    m_ack_o;
    logic [N_MASTERS-1:0]    m_err_o;

    logic [31:0]             s_adr_o;
    logic [31:0]             s_dat_o;
    logic [2:0]              s_cti_o;
    logic [3:0]              s_sel_o;
    logic                    s_we_o;
    logic [32*N_SLAVES-1:0]  s_dat_i;
    logic [N_SLAVES-1:0]     s_cyc_o;
    logic [N_SLAVES-1:0]     s_stb_o;
    logic [N_SLAVES-1:0]     s_ack_i;
    logic [N_SLAVES-1:0]     s_err_i;

    modport master (
        output m_adr_i, m_dat_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );

    modport slave (
        input  m_adr_i, m_dat_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );
endinterface

// File: rtl/wb_rr_interconnect.sv
// Shared-bus Wishbone interconnect: masters arbitrated (fixed or round-robin) onto mask/base
// decoded slaves, one transfer at a time, with unmapped-address error and a stall watchdog.
module wb_rr_interconnect #(
    parameter int                    N_MASTERS = 5,
    parameter int                    N_SLAVES  = 6,
    parameter logic [32*N_SLAVES-1:0] SLV_BASE = {N_SLAVES{32'h0}},
    parameter logic [32*N_SLAVES-1:0] SLV_MASK = {N_SLAVES{32'hE0000000}},
    parameter int                    ARB_MODE  = 1,
    parameter int                    TIMEOUT   = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    wb_rr_interconnect_if.slave   bus,
    output logic [N_MASTERS-1:0]  grant_o,
    output logic                  timeout_o
);
    localparam int MIDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t               r_state;
    logic [N_MASTERS-1:0] r_grant;
    logic [MIDX_W-1:0]    r_gidx;
    logic [MIDX_W-1:0]    r_rr_ptr;
    logic [15:0]          r_wd_cnt;
    logic                 r_unm_err;

    logic [MIDX_W-1:0]    w_win_idx;
    logic                 w_win_found;
    logic                 w_in_grant;
    logic [31:0]          w_g_adr, w_g_dat, w_rdat;
    logic [2:0]           w_g_cti;
    logic [3:0]           w_g_sel;
    logic                 w_g_we, w_g_cyc, w_g_stb;
    logic [N_SLAVES-1:0]  w_match;
    logic                 w_hit, w_s_ack, w_s_err, w_stall, w_wd_fire;
    logic [N_MASTERS-1:0] w_ack_vec, w_err_vec;

    assign w_in_grant = (r_state == S_GRANT);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin : arbiter
        w_win_idx   = '0;
        w_win_found = 1'b0;
        if (ARB_MODE == 0) begin
            for (int j = N_MASTERS - 1; j >= 0; j--) begin
                if (bus.m_cyc_i[j]) begin
                    w_win_idx   = MIDX_W'(j);
                    w_win_found = 1'b1;
                end
            end
        end else begin
            // Two ascending passes: indices above the pointer first, then wrap to the rest.
            for (int j = 0; j < N_MASTERS; j++) begin
                if (!w_win_found && bus.m_cyc_i[j] && (MIDX_W'(j) > r_rr_ptr)) begin
                    w_win_idx   = MIDX_W'(j);
                    w_win_found = 1'b1;
                end
            end
            for (int j = 0; j < N_MASTERS; j++) begin
                if (!w_win_found && bus.m_cyc_i[j]) begin
                    w_win_idx   = MIDX_W'(j);
                    w_win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin : master_mux
        w_g_adr = '0;
        w_g_dat = '0;
        w_g_cti = '0;
        w_g_sel = '0;
        w_g_we  = 1'b0;
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (w_in_grant && (r_gidx == MIDX_W'(j))) begin
                w_g_adr = bus.m_adr_i[32*j +: 32];
                w_g_dat = bus.m_dat_i[32*j +: 32];
                w_g_cti = bus.m_cti_i[3*j +: 3];
                w_g_sel = bus.m_sel_i[4*j +: 4];
                w_g_we  = bus.m_we_i[j];
                w_g_cyc = bus.m_cyc_i[j];
                w_g_stb = bus.m_cyc_i[j] & bus.m_stb_i[j];
            end
        end
    end

    // Descending scan so the lowest matching slave index wins overlapping windows.
    always_comb begin : decode
        w_hit   = 1'b0;
        w_match = '0;
        w_rdat  = '0;
        w_s_ack = 1'b0;
        w_s_err = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (w_in_grant &&
                ((w_g_adr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))) begin
                w_hit      = 1'b1;
                w_match    = '0;
                w_match[i] = 1'b1;
                w_rdat     = bus.s_dat_i[32*i +: 32];
                w_s_ack    = bus.s_ack_i[i];
                w_s_err    = bus.s_err_i[i];
            end
        end
    end

    assign w_stall   = w_g_stb & ~w_s_ack & ~w_s_err & ~r_unm_err;
    assign w_wd_fire = (TIMEOUT != 0) && w_stall && (r_wd_cnt == 16'(TIMEOUT - 1));

    // Responses are gated by the granted cyc so an ack arriving after cyc drops is discarded.
    always_comb begin : response
        w_ack_vec = '0;
        w_err_vec = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (w_g_cyc && (r_gidx == MIDX_W'(j))) begin
                w_ack_vec[j] = w_s_ack;
                w_err_vec[j] = w_s_err | r_unm_err | w_wd_fire;
            end
        end
    end

    assign bus.s_adr_o = w_g_adr;
    assign bus.s_dat_o = w_g_dat;
    assign bus.s_cti_o = w_g_cti;
    assign bus.s_sel_o = w_g_sel;
    assign bus.s_we_o  = w_g_we;
    assign bus.s_cyc_o = w_match & {N_SLAVES{w_g_cyc}};
    assign bus.s_stb_o = w_match & {N_SLAVES{w_g_stb}};
    assign bus.m_dat_o = w_rdat;
    assign bus.m_ack_o = w_ack_vec;
    assign bus.m_err_o = w_err_vec;
    assign grant_o     = r_grant;
    assign timeout_o   = w_wd_fire;

    // NOTE: registers are written with <= so every branch samples the pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= MIDX_W'(N_MASTERS - 1);
            r_wd_cnt  <= '0;
            r_unm_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wd_cnt  <= '0;
                    r_unm_err <= 1'b0;
                    if (w_win_found) begin
                        r_state  <= S_GRANT;
                        r_gidx   <= w_win_idx;
                        r_rr_ptr <= w_win_idx;
                        for (int j = 0; j < N_MASTERS; j++) begin
                            r_grant[j] <= (MIDX_W'(j) == w_win_idx);
                        end
                    end
                end
                S_GRANT: begin
                    r_unm_err <= w_g_stb & ~w_hit & ~r_unm_err;
                    r_wd_cnt  <= (w_stall && !w_wd_fire && (TIMEOUT != 0)) ? r_wd_cnt + 16'd1 : '0;
                    if (!w_g_cyc) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
